// File: rtl/mux_rst_dff.sv
// -----------------------------------------------------------------------------
// mux_rst_dff
//
// A WIDTH-bit D flip-flop whose synchronous reset is an explicit 2:1 mux in
// front of the storage element. The mux picks RESET_VALUE while reset is low
// and d otherwise. The flop loads the mux output on every rising clock edge.
// This block is the reference for the codebase's "reset-by-mux" style.
//
// Parameters:
//   WIDTH        data width of d and q (default 1)
//   RESET_VALUE  value loaded into q while reset is low (default all zeros)
//
// Ports (positional order reset, d, clk, q is relied upon by callers):
//   reset  in   1      synchronous, active-low; sampled only at rising clk
//   d      in   WIDTH  data to be registered; don't-care while reset is low
//   clk    in   1      sole clock
//   q      out  WIDTH  registered output, driven straight from the flop
//
// There is no enable and no handshake. The flop updates on every cycle.
// -----------------------------------------------------------------------------
module mux_rst_dff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  output logic [WIDTH-1:0] q
);

  // The next-state mux sits in its own combinational stage. When reset is
  // low the mux ignores d, so an X on d during reset cannot reach q.
  logic [WIDTH-1:0] next;

  assign next = (reset == 1'b0) ? RESET_VALUE : d;

  // The storage element holds only the plain register. Reset comes in through
  // the mux above, so the flop has no reset pin, and q stays X until the first
  // rising edge.
  always_ff @(posedge clk) begin
    q <= next;
  end

endmodule

// File: tb/tb_mux_rst_dff.sv
// -----------------------------------------------------------------------------
// tb_mux_rst_dff
//
// Bench for mux_rst_dff. It drives two instances with the same reset:
//   - u_dut1: WIDTH=1, RESET_VALUE=0 (default configuration)
//   - u_dut8: WIDTH=8, RESET_VALUE=8'hA5
// The reference model sets the state after each edge from the value that
// reset and d hold at that edge. If reset is low, the state is the reset
// constant. Otherwise the state is d. Reset or d glitches between edges must
// not be visible on q.
// -----------------------------------------------------------------------------
module tb_mux_rst_dff;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam logic       RV1 = 1'b0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;

  initial clk = 1'b0;
  always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

  mux_rst_dff u_dut1 (
    .reset (reset),
    .d     (d1),
    .clk   (clk),
    .q     (q1)
  );

  mux_rst_dff #(
    .WIDTH       (8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .reset (reset),
    .d     (d8),
    .clk   (clk),
    .q     (q8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];     // {q1, q8} expected after each edge
  logic [8:0] last_exp;     // value that q must hold between edges
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got {q1,q8}=%b_%h expected %b_%h",
               tag, $time, act[8], act[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Reference model: the value q must carry after an edge that sees (r, dv).
  function automatic logic [8:0] model_next(input logic r, input logic [7:0] dv);
    if (r == 1'b0) return {RV1, RV8};
    return {dv[0], dv};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // Runs one clock cycle. When glitch is set, the task first pulses reset low
  // and toggles d between edges, and checks that q holds. It then applies the
  // final (r, dv) before the rising edge and checks q just after that edge.
  task automatic drive_cycle(input logic r, input logic [7:0] dv, input bit glitch);
    logic [8:0] got;
    @(negedge clk);
    if (glitch) begin
      reset = 1'b0;
      d8    = ~dv;
      d1    = ~dv[0];
      #1;
      check("async_hold", {q1, q8}, last_exp);
      reset = 1'b1;
      d8    = 8'($urandom);
      d1    = 1'($urandom);
      #1;
      check("glitch_hold", {q1, q8}, last_exp);
    end
    #1;
    reset = r;
    d8    = dv;
    d1    = dv[0];
    exp_q.push_back(model_next(r, dv));
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("edge", {q1, q8}, got);
    last_exp = got;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    d1    = 1'b0;
    d8    = 8'h00;

    // Before the first edge q is undefined.
    #1;
    check("powerup_x", {q1, q8}, 9'bx);

    // reset drops at t=2 and d rises at t=3. The first edge (t=5) loads the
    // reset constant.
    #1 reset = 1'b0;
    #1 begin d1 = 1'b1; d8 = 8'h3C; end
    exp_q.push_back(model_next(1'b0, 8'h3C));
    @(posedge clk);
    #1;
    last_exp = exp_q.pop_front();
    check("first_edge_reset", {q1, q8}, last_exp);

    // Directed cases
    drive_cycle(1'b0, 8'hFF, 1'b0);   // reset held: d ignored
    drive_cycle(1'b0, 8'hxx, 1'b0);   // X on d during reset must not leak
    drive_cycle(1'b0, 8'h5A, 1'b1);   // glitches while in reset
    drive_cycle(1'b1, 8'h3C, 1'b0);   // release loads d on first edge
    drive_cycle(1'b1, 8'h01, 1'b0);   // normal capture 1
    drive_cycle(1'b1, 8'h00, 1'b0);   // normal capture 0
    drive_cycle(1'b1, 8'hFF, 1'b0);   // q = 1 established
    drive_cycle(1'b1, 8'hFF, 1'b1);   // reset pulse between edges: no effect
    drive_cycle(1'b0, 8'hFF, 1'b0);   // mid-stream reset wins over d
    drive_cycle(1'b1, 8'hFF, 1'b0);   // release
    drive_cycle(1'b1, 8'h00, 1'b1);   // d glitch within a cycle is filtered
    drive_cycle(1'b0, 8'h3C, 1'b0);   // parameter check: A5 on reset edge
    drive_cycle(1'b1, 8'h3C, 1'b0);   // then 3C one edge after release

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      drive_cycle((($urandom_range(0, 3)) != 0) ? 1'b1 : 1'b0,
                  8'($urandom), bit'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
